// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared types and constants for the count sequencer.
// Holds the FSM state encoding and the counter-direction codes.
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/seq_pos_mirror.sv
// seq_pos_mirror: shadows the managed up/down counter pair and
// flags wrap-around one cycle after the wrapping step.
module seq_pos_mirror
    import count_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sel,
    output logic [CNT_W-1:0] o_up_pos,
    output logic [CNT_W-1:0] o_dn_pos,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_up;
    logic [CNT_W-1:0] r_dn;
    logic             r_wrap;

    logic w_up_step;
    logic w_dn_step;
    logic w_wrap;

    assign w_up_step = i_en && (i_sel == DIR_UP);
    assign w_dn_step = i_en && (i_sel == DIR_DOWN);

    // Wrap is judged on the pre-step value so the pulse lines up with the new position.
    assign w_wrap = (w_up_step && (r_up == MAX)) ||
                    (w_dn_step && (r_dn == ZERO));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_up   <= ZERO;
            r_dn   <= MAX;
            r_wrap <= 1'b0;
        end else begin
            if (w_up_step) begin
                r_up <= r_up + ONE;
            end
            if (w_dn_step) begin
                r_dn <= r_dn - ONE;
            end
            r_wrap <= w_wrap;
        end
    end

    assign o_up_pos = r_up;
    assign o_dn_pos = r_dn;
    assign o_wrap   = r_wrap;

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: issues a burst of count enables to an up/down counter pair.
// Define SEQ_ABORT_EN to add the abort input and aborted status output.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    output logic             cnt_en,
    output logic             cnt_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] up_pos,
    output logic [CNT_W-1:0] dn_pos,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic             r_dir;
    logic [CNT_W-1:0] r_rem;

    logic w_accept;
    logic w_last;

    assign w_accept = cmd_valid && (r_state == IDLE);
    assign w_last   = (r_rem == ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (cmd_steps == ZERO) ? DONE : RUN;
                end
            end
            RUN: begin
`ifdef SEQ_ABORT_EN
                if (w_last || abort) begin
                    w_next = DONE;
                end
`else
                if (w_last) begin
                    w_next = DONE;
                end
`endif
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        cnt_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            RUN: begin
                cnt_en = 1'b1;
                busy   = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Direction and step count are frozen at acceptance; later cmd_* changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir <= DIR_UP;
            r_rem <= ZERO;
        end else if (w_accept) begin
            r_dir <= cmd_dir;
            r_rem <= cmd_steps;
        end else if (r_state == RUN) begin
            r_rem <= r_rem - ONE;
        end
    end

`ifdef SEQ_ABORT_EN
    logic r_aborted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aborted <= 1'b0;
        end else if (w_accept) begin
            r_aborted <= 1'b0;
        end else if ((r_state == RUN) && abort) begin
            r_aborted <= (r_rem > ONE);
        end
    end

    assign aborted = r_aborted;
`endif

    assign cnt_sel = r_dir;

    seq_pos_mirror #(
        .CNT_W (CNT_W)
    ) u_mirror (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (cnt_en),
        .i_sel    (cnt_sel),
        .o_up_pos (up_pos),
        .o_dn_pos (dn_pos),
        .o_wrap   (wrap)
    );

endmodule
